// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the Fifo push-side arbiter.
// State encoding, default parameters and a constant-width helper.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_DW        = 8;
    localparam int DEF_MAX_BURST = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NREQ so non-power-of-2 counts never produce unused codes.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    localparam int IW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] j;

    assign any = |req;

    // Scan farthest-first so the candidate closest to ptr is written last and wins.
    always_comb begin
        idx = '0;
        j   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % NREQ);
            if (req[j]) idx = j;
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares one Fifo push port between NREQ producers: round-robin grant,
// bursts of up to MAX_BURST beats, push gated by fifo_full.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = DEF_MAX_BURST,
    localparam int IW       = clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               fifo_full,
    output logic               fifo_push,
    output logic [DW-1:0]      fifo_din,
    output logic [IW-1:0]      grant_id,
    output logic               busy
);

    localparam int            BW      = clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] LAST    = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

    state_t        state, state_nx;
    logic [IW-1:0] owner, owner_nx;
    logic [IW-1:0] rr_ptr, rr_ptr_nx;
    logic [BW-1:0] beat_cnt, beat_nx;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          own_valid;
    logic          xfer;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign own_valid = req_valid[owner];
    assign xfer      = (state == ST_BURST) & own_valid & ~fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_ptr_nx;
            beat_cnt <= beat_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        rr_ptr_nx = rr_ptr;
        beat_nx   = beat_cnt;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nx = ST_BURST;
                    owner_nx = pick_idx;
                    beat_nx  = '0;
                end
            end
            ST_BURST: begin
                if (xfer) beat_nx = beat_cnt + 1'b1;
                // A full Fifo alone stalls the owner; only a completed burst or a dropped valid releases.
                if ((xfer && beat_cnt == LAST) || (!own_valid && !xfer)) begin
                    state_nx  = ST_IDLE;
                    rr_ptr_nx = (owner == LAST_ID) ? '0 : owner + 1'b1;
                    beat_nx   = '0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        fifo_push = 1'b0;
        fifo_din  = '0;
        grant_id  = '0;
        busy      = 1'b0;
        if (!rst && state == ST_BURST) begin
            busy             = 1'b1;
            grant_id         = owner;
            req_ready[owner] = ~fifo_full;
            fifo_push        = xfer;
            fifo_din         = req_data[int'(owner) * DW +: DW];
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter with a depth-4 Fifo model on the push side.
// Each scenario task drives per-cycle vectors and compares against hand-derived values.
module tb_fifo_push_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    typedef struct packed {
        logic        r;
        logic [3:0]  v;
        logic [31:0] d;
        logic        p;
        logic        b;
        logic [1:0]  g;
        logic        pu;
        logic [3:0]  rdy;
        logic [7:0]  din;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    req_ready;
    logic               fifo_full;
    logic               fifo_push;
    logic [DW-1:0]      fifo_din;
    logic [1:0]         grant_id;
    logic               busy;
    logic               fifo_pop = 1'b0;
    int                 fcnt = 0;
    int                 checks = 0;
    int                 errors = 0;

    always #5 clk = ~clk;

    fifo_push_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_push (fifo_push),
        .fifo_din  (fifo_din),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    // Depth-4 Fifo occupancy; contents are not needed since pushes are checked at the port.
    assign fifo_full = (fcnt == 4);
    always @(posedge clk) begin
        if (rst) fcnt <= 0;
        else     fcnt <= fcnt + int'(fifo_push) - int'(fifo_pop && fcnt > 0);
    end

    always @(negedge clk) begin
        #2;
        checks++;
        if (fifo_push && fifo_full) begin
            errors++;
            $display("FAIL push_into_full t=%0t push=%b full=%b", $time, fifo_push, fifo_full);
        end
        checks++;
        if (!$onehot0(req_ready)) begin
            errors++;
            $display("FAIL ready_onehot0 t=%0t ready=%b", $time, req_ready);
        end
        checks++;
        if (fifo_push !== |(req_ready & req_valid)) begin
            errors++;
            $display("FAIL push_vs_ready t=%0t push=%b expected %b", $time, fifo_push, |(req_ready & req_valid));
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        fifo_pop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            rst = 1'b1; req_valid = 4'hF; req_data = 32'hDEADBEEF; fifo_pop = 1'b0; #1;
            checks++;
            if ({req_ready, fifo_push, fifo_din, grant_id, busy} !== 16'h0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d got ready=%b push=%b din=%h gid=%0d busy=%b expected all 0",
                         c, req_ready, fifo_push, fifo_din, grant_id, busy);
            end
            @(negedge clk);
        end
        rst = 1'b0; req_valid = '0; #1;
        checks++;
        if ({req_ready, fifo_push, fifo_din, grant_id, busy} !== 16'h0) begin
            errors++;
            $display("FAIL idle_after_reset got ready=%b push=%b din=%h gid=%0d busy=%b expected all 0",
                     req_ready, fifo_push, fifo_din, grant_id, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        vec_t t [8];
        t = '{
            '{1'b0, 4'b0100, 32'h00110000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00},
            '{1'b0, 4'b0100, 32'h00110000, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h11},
            '{1'b0, 4'b0100, 32'h00220000, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h22},
            '{1'b0, 4'b0100, 32'h00330000, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h33},
            '{1'b0, 4'b0100, 32'h00440000, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h44},
            '{1'b0, 4'b0100, 32'h00550000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00},
            '{1'b0, 4'b0100, 32'h00550000, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h55},
            '{1'b0, 4'b0000, 32'h00550000, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0000, 8'h00}
        };
        for (int c = 0; c < 8; c++) begin
            rst = t[c].r; req_valid = t[c].v; req_data = t[c].d; fifo_pop = t[c].p; #1;
            checks++;
            if ({busy, grant_id, fifo_push, req_ready} !== {t[c].b, t[c].g, t[c].pu, t[c].rdy}) begin
                errors++;
                $display("FAIL single_ctrl cyc %0d got busy=%b gid=%0d push=%b ready=%b expected busy=%b gid=%0d push=%b ready=%b",
                         c, busy, grant_id, fifo_push, req_ready, t[c].b, t[c].g, t[c].pu, t[c].rdy);
            end
            if (fifo_push || !busy) begin
                checks++;
                if (fifo_din !== t[c].din) begin
                    errors++;
                    $display("FAIL single_din cyc %0d got %h expected %h", c, fifo_din, t[c].din);
                end
            end
            if (c == 5) begin
                checks++;
                if (fifo_full !== 1'b1) begin
                    errors++;
                    $display("FAIL single_full_after_44 got %b expected 1", fifo_full);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_all_valid();
        logic       eb;
        logic [1:0] eg;
        rst = 1'b0; req_data = 32'hA3A2A1A0; fifo_pop = 1'b1;
        for (int k = 0; k < 25; k++) begin
            req_valid = 4'hF; #1;
            eb = (k % 5) != 0;
            eg = eb ? 2'((k / 5) % 4) : 2'd0;
            checks++;
            if ({busy, grant_id, fifo_push, req_ready} !== {eb, eg, eb, eb ? 4'(1 << eg) : 4'b0000}) begin
                errors++;
                $display("FAIL allvalid_ctrl cyc %0d got busy=%b gid=%0d push=%b ready=%b expected busy=%b gid=%0d push=%b",
                         k, busy, grant_id, fifo_push, req_ready, eb, eg, eb);
            end
            checks++;
            if (fifo_din !== (eb ? 8'hA0 + 8'(eg) : 8'h00)) begin
                errors++;
                $display("FAIL allvalid_din cyc %0d got %h expected %h", k, fifo_din, eb ? 8'hA0 + 8'(eg) : 8'h00);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full_hold();
        vec_t t [15];
        t = '{
            '{1'b0, 4'b0001, 32'h000000C0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00},
            '{1'b0, 4'b0001, 32'h000000C0, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'hC0},
            '{1'b0, 4'b0001, 32'h000000C1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'hC1},
            '{1'b0, 4'b0001, 32'h000000C2, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'hC2},
            '{1'b0, 4'b0001, 32'h000000C3, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'hC3},
            '{1'b0, 4'b0010, 32'h0000A500, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00},
            '{1'b0, 4'b0010, 32'h0000A500, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, 8'h00},
            '{1'b0, 4'b0010, 32'h0000A500, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, 8'h00},
            '{1'b0, 4'b0010, 32'h0000A500, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, 8'h00},
            '{1'b0, 4'b0010, 32'h0000A500, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0000, 8'h00},
            '{1'b0, 4'b0010, 32'h0000A500, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 8'hA5},
            '{1'b0, 4'b0010, 32'h0000A500, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 8'hA5},
            '{1'b0, 4'b0010, 32'h0000A500, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 8'hA5},
            '{1'b0, 4'b0010, 32'h0000A500, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 8'hA5},
            '{1'b0, 4'b0010, 32'h0000A500, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00}
        };
        for (int c = 0; c < 15; c++) begin
            rst = t[c].r; req_valid = t[c].v; req_data = t[c].d; fifo_pop = t[c].p; #1;
            checks++;
            if ({busy, grant_id, fifo_push, req_ready} !== {t[c].b, t[c].g, t[c].pu, t[c].rdy}) begin
                errors++;
                $display("FAIL fullhold_ctrl cyc %0d got busy=%b gid=%0d push=%b ready=%b expected busy=%b gid=%0d push=%b ready=%b",
                         c, busy, grant_id, fifo_push, req_ready, t[c].b, t[c].g, t[c].pu, t[c].rdy);
            end
            if (fifo_push || !busy) begin
                checks++;
                if (fifo_din !== t[c].din) begin
                    errors++;
                    $display("FAIL fullhold_din cyc %0d got %h expected %h", c, fifo_din, t[c].din);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_drop_valid();
        vec_t t [10];
        t = '{
            '{1'b0, 4'b0100, 32'h00770000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00},
            '{1'b0, 4'b0100, 32'h00770000, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h77},
            '{1'b0, 4'b1001, 32'h01000099, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0100, 8'h00},
            '{1'b0, 4'b1001, 32'h01000099, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00},
            '{1'b0, 4'b1001, 32'h01000099, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000, 8'h01},
            '{1'b0, 4'b1001, 32'h02000099, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000, 8'h02},
            '{1'b0, 4'b0011, 32'h02005599, 1'b1, 1'b1, 2'd3, 1'b0, 4'b1000, 8'h00},
            '{1'b0, 4'b0011, 32'h02005599, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00},
            '{1'b0, 4'b0011, 32'h02005599, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h99},
            '{1'b0, 4'b0000, 32'h02005599, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0001, 8'h00}
        };
        for (int c = 0; c < 10; c++) begin
            rst = t[c].r; req_valid = t[c].v; req_data = t[c].d; fifo_pop = t[c].p; #1;
            checks++;
            if ({busy, grant_id, fifo_push, req_ready} !== {t[c].b, t[c].g, t[c].pu, t[c].rdy}) begin
                errors++;
                $display("FAIL drop_ctrl cyc %0d got busy=%b gid=%0d push=%b ready=%b expected busy=%b gid=%0d push=%b ready=%b",
                         c, busy, grant_id, fifo_push, req_ready, t[c].b, t[c].g, t[c].pu, t[c].rdy);
            end
            if (fifo_push || !busy) begin
                checks++;
                if (fifo_din !== t[c].din) begin
                    errors++;
                    $display("FAIL drop_din cyc %0d got %h expected %h", c, fifo_din, t[c].din);
                end
            end
            @(negedge clk);
        end
    endtask

    // Follows test_drop_valid directly: rr_ptr is 1 on entry, so a stale pointer would pick requester 1.
    task automatic test_reset_mid_burst();
        vec_t t [7];
        t = '{
            '{1'b0, 4'b0100, 32'h00210000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00},
            '{1'b0, 4'b0100, 32'h00210000, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h21},
            '{1'b0, 4'b0100, 32'h00220000, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h22},
            '{1'b1, 4'b0011, 32'h00224140, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00},
            '{1'b0, 4'b0011, 32'h00224140, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00},
            '{1'b0, 4'b0011, 32'h00224140, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h40},
            '{1'b0, 4'b0000, 32'h00224140, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0001, 8'h00}
        };
        for (int c = 0; c < 7; c++) begin
            rst = t[c].r; req_valid = t[c].v; req_data = t[c].d; fifo_pop = t[c].p; #1;
            checks++;
            if ({busy, grant_id, fifo_push, req_ready} !== {t[c].b, t[c].g, t[c].pu, t[c].rdy}) begin
                errors++;
                $display("FAIL rstmid_ctrl cyc %0d got busy=%b gid=%0d push=%b ready=%b expected busy=%b gid=%0d push=%b ready=%b",
                         c, busy, grant_id, fifo_push, req_ready, t[c].b, t[c].g, t[c].pu, t[c].rdy);
            end
            if (fifo_push || !busy) begin
                checks++;
                if (fifo_din !== t[c].din) begin
                    errors++;
                    $display("FAIL rstmid_din cyc %0d got %h expected %h", c, fifo_din, t[c].din);
                end
            end
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        do_reset();
        test_all_valid();
        do_reset();
        test_full_hold();
        do_reset();
        test_drop_valid();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
